axil_bus_nport: RTL
===================

AXIL_BUS_NPORT -- requirements
Module: axil_bus_nport

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-003 SHALL have parameter N_PORTS, default 2, number of downstream ports; legal range 1..8.
REQ-004 SHALL have parameter REGION_SHIFT, default 4, log2 of the per-port window size in bytes.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 64; used only under BUS_TIMEOUT_EN.
REQ-006 SHALL be clocked by one clock with a synchronous active-low reset: s0_axi_aclk and s0_axi_aresetn (already decided).
REQ-007 Upstream ports SHALL be s0_axi_* (AXI4-Lite slave side), one line each:
 - s0_axi_aclk  in  1  clock
 - s0_axi_aresetn  in  1  sync reset, active-low
 - s0_axi_awaddr in ADDR_WIDTH; s0_axi_awvalid in 1; s0_axi_awready out 1
 - s0_axi_wdata in DATA_WIDTH; s0_axi_wstrb in DATA_WIDTH/8; s0_axi_wvalid in 1; s0_axi_wready out 1
 - s0_axi_bresp out 2; s0_axi_bvalid out 1; s0_axi_bready in 1
 - s0_axi_araddr in ADDR_WIDTH; s0_axi_arvalid in 1; s0_axi_arready out 1
 - s0_axi_rdata out DATA_WIDTH; s0_axi_rresp out 2; s0_axi_rvalid out 1; s0_axi_rready in 1
REQ-008 Downstream ports SHALL be m_axi_*, with the same signal set mirrored in direction, flattened as N_PORTS x field width; port k occupies slice [k*W +: W], and 1-bit signals are N_PORTS wide.

Function
REQ-009 Decode: port index = addr[ADDR_WIDTH-1:REGION_SHIFT]; an index >= N_PORTS SHALL be unmapped.
REQ-010 The write and read paths SHALL be independent FSMs and SHALL operate concurrently, including on the same port.
REQ-011 Write FSM SHALL have states W_IDLE, W_ISSUE, W_RESP, W_BACK.
REQ-012 W_IDLE: awready and wready SHALL each be 1 until their own handshake completes. AW and W are captured independently, in either order. Once both are held, go to W_ISSUE, or to W_BACK with bresp=2'b11 (DECERR) if the address is unmapped.
REQ-013 W_ISSUE: assert m awvalid[k] and wvalid[k] with registered addr/data/strb. Each valid SHALL hold until its own ready, and SHALL drop the cycle after acceptance. Go to W_RESP when both are accepted.
REQ-014 W_RESP: m bready[k]=1; on bvalid[k], capture bresp and go to W_BACK.
REQ-015 W_BACK: s0 bvalid=1 with the captured bresp until s0 bready, then go to W_IDLE. awready and wready SHALL be 0 in every state except W_IDLE.
REQ-016 Read FSM SHALL have states R_IDLE, R_ISSUE, R_DATA, R_BACK.
REQ-017 R_IDLE: arready=1. On arvalid, capture araddr and go to R_ISSUE, or to R_BACK with rresp=2'b11 and rdata=0 if unmapped.
REQ-018 R_ISSUE: m arvalid[k]=1 until arready[k], then go to R_DATA.
REQ-019 R_DATA: m rready[k]=1; on rvalid[k], capture rdata and rresp and go to R_BACK.
REQ-020 R_BACK: s0 rvalid=1 with the captured data until s0 rready, then go to R_IDLE.
REQ-021 All outputs SHALL be registered. Only port k's valid/ready outputs may be asserted; all other ports SHALL see 0.
REQ-022 Minimum latency: AW+W accepted in cycle 0 -> m valids asserted in cycle 1; with zero-wait downstream, s0 bvalid asserted in cycle 3. Same for reads.
REQ-023 The upstream response SHALL pass through the downstream bresp/rresp values 0..3 unchanged.
REQ-024 Exactly one outstanding transaction per direction; no new address SHALL be accepted until the current response handshake completes.

Reset
REQ-025 When s0_axi_aresetn=0 at a clock edge, all valid/ready outputs, data, addr, strb and resp SHALL be 0 and both FSMs SHALL return to IDLE, including mid-transaction.
REQ-026 The first cycle after reset release SHALL drive awready=wready=arready=1.

Configuration
REQ-027 With BUS_TIMEOUT_EN defined: a per-direction counter SHALL count cycles spent in ISSUE plus RESP/DATA. On reaching TIMEOUT_CYCLES, the block SHALL drop all m valid/ready for that port, respond 2'b10 (SLVERR) with rdata=0, and go to BACK.
REQ-028 Without BUS_TIMEOUT_EN: no counter logic SHALL exist and the block SHALL wait indefinitely.

Verification
REQ-029 Write 0x14 data 0xA5A5A5A5 strb 0xF, N_PORTS=2 -> port 1 sees awaddr 0x14, wdata 0xA5A5A5A5; port 0 valids stay 0; s0 bresp=0.
REQ-030 W presented 3 cycles before AW at 0x04 -> both captured; single port 0 transfer; bresp=0.
REQ-031 Read 0x38 with N_PORTS=2 -> no downstream activity; rresp=2'b11, rdata=0.
REQ-032 Concurrent write 0x00 and read 0x18 with port 1 rdata 0x12345678 -> both complete; rdata=0x12345678, rresp=0.
REQ-033 Reset asserted during W_RESP -> all outputs 0 next cycle; a subsequent write completes normally.
REQ-034 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, port 0 never asserts arready -> rresp=2'b10 within 17 cycles of R_ISSUE entry; m arvalid[0] deasserted.

Source files
------------

// File: rtl/axil_bus_nport_if.sv
// AXI4-Lite bundle shared by the upstream port and the flattened downstream ports.
// Port k of an N-wide bundle occupies slice [k*W +: W]; 1-bit signals are N wide.
interface axil_bus_nport_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned N          = 1
);
    logic [N*ADDR_WIDTH-1:0]     awaddr;
    logic [N-1:0]                awvalid;
    logic [N-1:0]                awready;
    logic [N*DATA_WIDTH-1:0]     wdata;
    logic [N*(DATA_WIDTH/8)-1:0] wstrb;
    logic [N-1:0]                wvalid;
    logic [N-1:0]                wready;
    logic [N*2-1:0]              bresp;
    logic [N-1:0]                bvalid;
    logic [N-1:0]                bready;
    logic [N*ADDR_WIDTH-1:0]     araddr;
    logic [N-1:0]                arvalid;
    logic [N-1:0]                arready;
    logic [N*DATA_WIDTH-1:0]     rdata;
    logic [N*2-1:0]              rresp;
    logic [N-1:0]                rvalid;
    logic [N-1:0]                rready;

    // Transaction initiator
    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    // Transaction target
    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_bus_nport.sv
// AXI4-Lite 1-to-N address-decoded bridge: one outstanding write and one
// outstanding read, handled by independent FSMs. All outputs are registered.
// Optional feature macro: BUS_TIMEOUT_EN (per-direction downstream timeout,
// answered with SLVERR).
module axil_bus_nport #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned N_PORTS        = 2,
    parameter int unsigned REGION_SHIFT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             s0_axi_aclk,
    input  logic             s0_axi_aresetn,
    axil_bus_nport_if.slave  s0_axi,
    axil_bus_nport_if.master m_axi
);
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned IW = ADDR_WIDTH - REGION_SHIFT;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP, W_BACK} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA, R_BACK} r_state_e;

    // One-hot port select; all zero when the window index is unmapped
    function automatic logic [N_PORTS-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [N_PORTS-1:0] sel;
        logic [IW-1:0]      idx;
        sel = '0;
        idx = a[ADDR_WIDTH-1:REGION_SHIFT];
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (32'(idx) == k) sel[k] = 1'b1;
        end
        return sel;
    endfunction

    w_state_e               w_state_q, w_state_d;
    logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]          wstrb_q, wstrb_d;
    logic [N_PORTS-1:0]     wsel_q, wsel_d;
    logic [N_PORTS-1:0]     m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
    logic [N_PORTS-1:0]     m_bready_q, m_bready_d;
    logic                   s_awready_q, s_awready_d, s_wready_q, s_wready_d;
    logic                   s_bvalid_q, s_bvalid_d;
    logic [1:0]             s_bresp_q, s_bresp_d;

    r_state_e               r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [N_PORTS-1:0]     rsel_q, rsel_d;
    logic [N_PORTS-1:0]     m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d;
    logic                   s_arready_q, s_arready_d;
    logic                   s_rvalid_q, s_rvalid_d;
    logic [DATA_WIDTH-1:0]  s_rdata_q, s_rdata_d;
    logic [1:0]             s_rresp_q, s_rresp_d;

    logic [1:0]             b_resp_sel, r_resp_sel;
    logic [DATA_WIDTH-1:0]  r_data_sel;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
`else
    // Timeout length is only meaningful in the timeout build
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Pick the response fields of the port owning each outstanding transaction
    always_comb begin
        b_resp_sel = '0;
        r_resp_sel = '0;
        r_data_sel = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (wsel_q[k]) b_resp_sel = m_axi.bresp[k*2 +: 2];
            if (rsel_q[k]) begin
                r_resp_sel = m_axi.rresp[k*2 +: 2];
                r_data_sel = m_axi.rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Write FSM next state and registered outputs
    always_comb begin
        w_state_d   = w_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wsel_d      = wsel_q;
        m_awvalid_d = m_awvalid_q;
        m_wvalid_d  = m_wvalid_q;
        m_bready_d  = m_bready_q;
        s_awready_d = s_awready_q;
        s_wready_d  = s_wready_q;
        s_bvalid_d  = s_bvalid_q;
        s_bresp_d   = s_bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (s0_axi.awvalid && s_awready_q) begin
                    awaddr_d  = s0_axi.awaddr;
                    aw_held_d = 1'b1;
                end
                if (s0_axi.wvalid && s_wready_q) begin
                    wdata_d  = s0_axi.wdata;
                    wstrb_d  = s0_axi.wstrb;
                    w_held_d = 1'b1;
                end
                // Each channel stays ready until its own beat is held
                s_awready_d = !aw_held_d;
                s_wready_d  = !w_held_d;
                if (aw_held_d && w_held_d) begin
                    aw_held_d   = 1'b0;
                    w_held_d    = 1'b0;
                    s_awready_d = 1'b0;
                    s_wready_d  = 1'b0;
                    wsel_d      = decode(awaddr_d);
                    if (|wsel_d) begin
                        m_awvalid_d = wsel_d;
                        m_wvalid_d  = wsel_d;
                        w_state_d   = W_ISSUE;
                    end else begin
                        s_bvalid_d = 1'b1;
                        s_bresp_d  = 2'b11;
                        w_state_d  = W_BACK;
                    end
                end
            end
            W_ISSUE: begin
                m_awvalid_d = m_awvalid_q & ~m_axi.awready;
                m_wvalid_d  = m_wvalid_q & ~m_axi.wready;
                if (!(|m_awvalid_d) && !(|m_wvalid_d)) begin
                    m_bready_d = wsel_q;
                    w_state_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (|(m_axi.bvalid & m_bready_q)) begin
                    m_bready_d = '0;
                    s_bresp_d  = b_resp_sel;
                    s_bvalid_d = 1'b1;
                    w_state_d  = W_BACK;
                end
            end
            W_BACK: begin
                if (s0_axi.bready) begin
                    s_bvalid_d  = 1'b0;
                    s_awready_d = 1'b1;
                    s_wready_d  = 1'b1;
                    w_state_d   = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
`ifdef BUS_TIMEOUT_EN
        w_cnt_d = '0;
        if (w_state_q == W_ISSUE || w_state_q == W_RESP) begin
            if (w_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                m_awvalid_d = '0;
                m_wvalid_d  = '0;
                m_bready_d  = '0;
                s_bresp_d   = 2'b10;
                s_bvalid_d  = 1'b1;
                w_state_d   = W_BACK;
            end else begin
                w_cnt_d = w_cnt_q + 1'b1;
            end
        end
`endif
    end

    // Read FSM next state and registered outputs
    always_comb begin
        r_state_d   = r_state_q;
        araddr_d    = araddr_q;
        rsel_d      = rsel_q;
        m_arvalid_d = m_arvalid_q;
        m_rready_d  = m_rready_q;
        s_arready_d = s_arready_q;
        s_rvalid_d  = s_rvalid_q;
        s_rdata_d   = s_rdata_q;
        s_rresp_d   = s_rresp_q;
        case (r_state_q)
            R_IDLE: begin
                s_arready_d = 1'b1;
                if (s0_axi.arvalid && s_arready_q) begin
                    s_arready_d = 1'b0;
                    araddr_d    = s0_axi.araddr;
                    rsel_d      = decode(s0_axi.araddr);
                    if (|rsel_d) begin
                        m_arvalid_d = rsel_d;
                        r_state_d   = R_ISSUE;
                    end else begin
                        s_rvalid_d = 1'b1;
                        s_rresp_d  = 2'b11;
                        s_rdata_d  = '0;
                        r_state_d  = R_BACK;
                    end
                end
            end
            R_ISSUE: begin
                if (|(m_arvalid_q & m_axi.arready)) begin
                    m_arvalid_d = '0;
                    m_rready_d  = rsel_q;
                    r_state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (|(m_axi.rvalid & m_rready_q)) begin
                    m_rready_d = '0;
                    s_rdata_d  = r_data_sel;
                    s_rresp_d  = r_resp_sel;
                    s_rvalid_d = 1'b1;
                    r_state_d  = R_BACK;
                end
            end
            R_BACK: begin
                if (s0_axi.rready) begin
                    s_rvalid_d  = 1'b0;
                    s_arready_d = 1'b1;
                    r_state_d   = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
`ifdef BUS_TIMEOUT_EN
        r_cnt_d = '0;
        if (r_state_q == R_ISSUE || r_state_q == R_DATA) begin
            if (r_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                m_arvalid_d = '0;
                m_rready_d  = '0;
                s_rresp_d   = 2'b10;
                s_rdata_d   = '0;
                s_rvalid_d  = 1'b1;
                r_state_d   = R_BACK;
            end else begin
                r_cnt_d = r_cnt_q + 1'b1;
            end
        end
`endif
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge s0_axi_aclk) begin
        if (!s0_axi_aresetn) begin
            w_state_q   <= W_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wsel_q      <= '0;
            m_awvalid_q <= '0;
            m_wvalid_q  <= '0;
            m_bready_q  <= '0;
            s_awready_q <= 1'b0;
            s_wready_q  <= 1'b0;
            s_bvalid_q  <= 1'b0;
            s_bresp_q   <= '0;
            r_state_q   <= R_IDLE;
            araddr_q    <= '0;
            rsel_q      <= '0;
            m_arvalid_q <= '0;
            m_rready_q  <= '0;
            s_arready_q <= 1'b0;
            s_rvalid_q  <= 1'b0;
            s_rdata_q   <= '0;
            s_rresp_q   <= '0;
`ifdef BUS_TIMEOUT_EN
            w_cnt_q     <= '0;
            r_cnt_q     <= '0;
`endif
        end else begin
            w_state_q   <= w_state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wsel_q      <= wsel_d;
            m_awvalid_q <= m_awvalid_d;
            m_wvalid_q  <= m_wvalid_d;
            m_bready_q  <= m_bready_d;
            s_awready_q <= s_awready_d;
            s_wready_q  <= s_wready_d;
            s_bvalid_q  <= s_bvalid_d;
            s_bresp_q   <= s_bresp_d;
            r_state_q   <= r_state_d;
            araddr_q    <= araddr_d;
            rsel_q      <= rsel_d;
            m_arvalid_q <= m_arvalid_d;
            m_rready_q  <= m_rready_d;
            s_arready_q <= s_arready_d;
            s_rvalid_q  <= s_rvalid_d;
            s_rdata_q   <= s_rdata_d;
            s_rresp_q   <= s_rresp_d;
`ifdef BUS_TIMEOUT_EN
            w_cnt_q     <= w_cnt_d;
            r_cnt_q     <= r_cnt_d;
`endif
        end
    end

    assign s0_axi.awready = s_awready_q;
    assign s0_axi.wready  = s_wready_q;
    assign s0_axi.bvalid  = s_bvalid_q;
    assign s0_axi.bresp   = s_bresp_q;
    assign s0_axi.arready = s_arready_q;
    assign s0_axi.rvalid  = s_rvalid_q;
    assign s0_axi.rdata   = s_rdata_q;
    assign s0_axi.rresp   = s_rresp_q;

    // Payload is broadcast; only the selected port ever sees a valid/ready
    assign m_axi.awaddr  = {N_PORTS{awaddr_q}};
    assign m_axi.wdata   = {N_PORTS{wdata_q}};
    assign m_axi.wstrb   = {N_PORTS{wstrb_q}};
    assign m_axi.araddr  = {N_PORTS{araddr_q}};
    assign m_axi.awvalid = m_awvalid_q;
    assign m_axi.wvalid  = m_wvalid_q;
    assign m_axi.bready  = m_bready_q;
    assign m_axi.arvalid = m_arvalid_q;
    assign m_axi.rready  = m_rready_q;
endmodule
